// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS decode definitions.
//   - opcode_e     : primary opcode values (instr[31:26]) understood by decode
//   - CTRL_*       : bit positions inside the packed ID/EX control bus
//   - ALU_OP_*     : alu_op field encodings handed to execute
//   - decode_ctrl  : opcode -> packed control bus
package mips_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  localparam int unsigned CTRL_REG_WRITE  = 0;
  localparam int unsigned CTRL_MEM_READ   = 1;
  localparam int unsigned CTRL_MEM_WRITE  = 2;
  localparam int unsigned CTRL_MEM_TO_REG = 3;
  localparam int unsigned CTRL_ALU_SRC    = 4;
  localparam int unsigned CTRL_REG_DST    = 5;
  localparam int unsigned CTRL_ALU_OP_LSB = 6;
  localparam int unsigned CTRL_ALU_OP_MSB = 7;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;

  // Branches and jumps are consumed in decode, so they produce an all-zero
  // control word just like an unknown opcode.
  function automatic logic [7:0] decode_ctrl(input logic [5:0] opcode);
    logic [7:0] ctrl;
    ctrl = '0;
    case (opcode)
      OP_RTYPE: begin
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_REG_DST]   = 1'b1;
        ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB] = ALU_OP_RTYPE;
      end
      OP_LW: begin
        ctrl[CTRL_REG_WRITE]  = 1'b1;
        ctrl[CTRL_MEM_READ]   = 1'b1;
        ctrl[CTRL_MEM_TO_REG] = 1'b1;
        ctrl[CTRL_ALU_SRC]    = 1'b1;
        ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB] = ALU_OP_ADD;
      end
      OP_SW: begin
        ctrl[CTRL_MEM_WRITE] = 1'b1;
        ctrl[CTRL_ALU_SRC]   = 1'b1;
        ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB] = ALU_OP_ADD;
      end
      OP_ADDI: begin
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_ALU_SRC]   = 1'b1;
        ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB] = ALU_OP_ADD;
      end
      default: ctrl = '0;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/register_file.sv
// register_file: 2-read / 1-write register file, R0 hardwired to zero.
// Ports:
//   i_clock, i_reset          posedge clock, synchronous active-low clear
//   i_write/i_waddr/i_wdata   write port (ignored for address 0)
//   i_raddr_a/i_raddr_b       combinational read addresses
//   o_rdata_a/o_rdata_b       read data
// Build option: DECODE_WB_BYPASS_EN forwards a same-cycle write to the read
// ports; without it a write becomes visible on the following cycle.
module register_file #(
  parameter int unsigned NB_DATA     = 32,
  parameter int unsigned NB_REGISTER = 5,
  parameter int unsigned N_REGISTERS = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_write,
  input  logic [NB_REGISTER-1:0] i_waddr,
  input  logic [NB_DATA-1:0]     i_wdata,
  input  logic [NB_REGISTER-1:0] i_raddr_a,
  input  logic [NB_REGISTER-1:0] i_raddr_b,
  output logic [NB_DATA-1:0]     o_rdata_a,
  output logic [NB_DATA-1:0]     o_rdata_b
);

  logic [NB_DATA-1:0] regs [N_REGISTERS];

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      regs <= '{default: '0};
    end else if (i_write && (i_waddr != '0)) begin
      regs[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata_a = (i_raddr_a == '0) ? '0 : regs[i_raddr_a];
    o_rdata_b = (i_raddr_b == '0) ? '0 : regs[i_raddr_b];
`ifdef DECODE_WB_BYPASS_EN
    if (i_write && (i_waddr != '0) && (i_waddr == i_raddr_a)) o_rdata_a = i_wdata;
    if (i_write && (i_waddr != '0) && (i_waddr == i_raddr_b)) o_rdata_b = i_wdata;
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: MIPS instruction decode (ID) stage.
// Ports:
//   i_clock, i_reset            posedge clock, synchronous active-low reset
//   i_valid                     stage enable; 0 freezes state and gates stall/pc_src
//   i_pc_next, i_instruction,
//   i_rs, i_rt                  fetch outputs
//   i_wb_write/addr/data        register-file writeback port
//   o_stall                     combinational load-use stall to fetch
//   o_pc_src, o_pc_branch       combinational branch/jump redirect to fetch
//   o_pc_next .. o_ctrl         registered ID/EX bundle
// Build option: DECODE_WB_BYPASS_EN (see register_file) makes a same-cycle
// writeback visible to both the ID/EX operands and the branch compare.
module decode_stage
  import mips_pkg::*;
#(
  parameter int unsigned NB_DATA     = 32,
  parameter int unsigned NB_REGISTER = 5,
  parameter int unsigned N_REGISTERS = 32,
  parameter int unsigned NB_CTRL     = 8
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic [NB_DATA-1:0]     i_pc_next,
  input  logic [NB_DATA-1:0]     i_instruction,
  input  logic [NB_REGISTER-1:0] i_rs,
  input  logic [NB_REGISTER-1:0] i_rt,
  input  logic                   i_wb_write,
  input  logic [NB_REGISTER-1:0] i_wb_addr,
  input  logic [NB_DATA-1:0]     i_wb_data,
  output logic                   o_stall,
  output logic                   o_pc_src,
  output logic [NB_DATA-1:0]     o_pc_branch,
  output logic [NB_DATA-1:0]     o_pc_next,
  output logic [NB_DATA-1:0]     o_data_rs,
  output logic [NB_DATA-1:0]     o_data_rt,
  output logic [NB_DATA-1:0]     o_immediate,
  output logic [NB_REGISTER-1:0] o_rs,
  output logic [NB_REGISTER-1:0] o_rt,
  output logic [NB_REGISTER-1:0] o_rd,
  output logic [NB_CTRL-1:0]     o_ctrl
);

  logic [5:0]         opcode;
  logic [NB_DATA-1:0] data_rs;
  logic [NB_DATA-1:0] data_rt;
  logic [NB_DATA-1:0] imm_ext;
  logic [NB_DATA-1:0] target;
  logic               taken;
  logic               hazard;
  logic               flush;
  logic [NB_CTRL-1:0] next_ctrl;

  register_file #(
    .NB_DATA     (NB_DATA),
    .NB_REGISTER (NB_REGISTER),
    .N_REGISTERS (N_REGISTERS)
  ) u_register_file (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_write   (i_wb_write),
    .i_waddr   (i_wb_addr),
    .i_wdata   (i_wb_data),
    .i_raddr_a (i_rs),
    .i_raddr_b (i_rt),
    .o_rdata_a (data_rs),
    .o_rdata_b (data_rt)
  );

  always_comb begin
    opcode  = i_instruction[31:26];
    imm_ext = {{(NB_DATA-16){i_instruction[15]}}, i_instruction[15:0]};

    // A load sitting in ID/EX whose destination feeds this instruction.
    // The instruction behind a taken branch is discarded, so it never stalls.
    hazard = o_ctrl[CTRL_MEM_READ] && (o_rt != '0) &&
             ((o_rt == i_rs) || (o_rt == i_rt)) && !flush;

    taken  = 1'b0;
    target = '0;
    case (opcode)
      OP_BEQ: begin
        taken  = (data_rs == data_rt);
        target = i_pc_next + imm_ext;
      end
      OP_BNE: begin
        taken  = (data_rs != data_rt);
        target = i_pc_next + imm_ext;
      end
      OP_J: begin
        taken  = 1'b1;
        target = {i_pc_next[NB_DATA-1:26], i_instruction[25:0]};
      end
      default: begin
        taken  = 1'b0;
        target = '0;
      end
    endcase

    // Priority: flush over stall over branch resolution.
    o_stall     = i_valid && hazard;
    o_pc_src    = i_valid && !hazard && !flush && taken;
    o_pc_branch = o_pc_src ? target : '0;

    next_ctrl = (flush || hazard) ? '0 : NB_CTRL'(decode_ctrl(opcode));
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      flush       <= 1'b0;
      o_pc_next   <= '0;
      o_data_rs   <= '0;
      o_data_rt   <= '0;
      o_immediate <= '0;
      o_rs        <= '0;
      o_rt        <= '0;
      o_rd        <= '0;
      o_ctrl      <= '0;
    end else if (i_valid) begin
      flush       <= o_pc_src;
      o_pc_next   <= i_pc_next;
      o_data_rs   <= data_rs;
      o_data_rt   <= data_rt;
      o_immediate <= imm_ext;
      o_rs        <= i_rs;
      o_rt        <= i_rt;
      o_rd        <= i_instruction[15:11];
      o_ctrl      <= next_ctrl;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic [31:0] i_pc_next;
  logic [31:0] i_instruction;
  logic [4:0]  i_rs;
  logic [4:0]  i_rt;
  logic        i_wb_write;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        o_stall;
  logic        o_pc_src;
  logic [31:0] o_pc_branch;
  logic [31:0] o_pc_next;
  logic [31:0] o_data_rs;
  logic [31:0] o_data_rt;
  logic [31:0] o_immediate;
  logic [4:0]  o_rs;
  logic [4:0]  o_rt;
  logic [4:0]  o_rd;
  logic [7:0]  o_ctrl;

  always #5 i_clock = ~i_clock;

  decode_stage #(
    .NB_DATA     (32),
    .NB_REGISTER (5),
    .N_REGISTERS (32),
    .NB_CTRL     (8)
  ) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_valid       (i_valid),
    .i_pc_next     (i_pc_next),
    .i_instruction (i_instruction),
    .i_rs          (i_rs),
    .i_rt          (i_rt),
    .i_wb_write    (i_wb_write),
    .i_wb_addr     (i_wb_addr),
    .i_wb_data     (i_wb_data),
    .o_stall       (o_stall),
    .o_pc_src      (o_pc_src),
    .o_pc_branch   (o_pc_branch),
    .o_pc_next     (o_pc_next),
    .o_data_rs     (o_data_rs),
    .o_data_rt     (o_data_rt),
    .o_immediate   (o_immediate),
    .o_rs          (o_rs),
    .o_rt          (o_rt),
    .o_rd          (o_rd),
    .o_ctrl        (o_ctrl)
  );

  localparam logic [31:0] NOP = 32'hFC00_0000;  // opcode 0x3F: decodes to nothing

  int n_cmp = 0;
  int n_bad = 0;
  logic started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [32];
  logic        m_flush;      // instruction now in decode follows a taken branch
  logic        m_bubble;     // ID/EX holds a squashed slot (only ctrl is meaningful)
  logic [4:0]  m_load_dst;   // destination of a load sitting in ID/EX, 0 if none
  logic [31:0] m_pc_next, m_rs_val, m_rt_val, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [7:0]  m_ctrl;
  logic        m_squash;
  logic        m_src_now;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
    if (i_wb_write && i_wb_addr == a) return i_wb_data;
`endif
    return m_regs[a];
  endfunction

  // Control word as a sum of named bit weights:
  // reg_write=1 mem_read=2 mem_write=4 mem_to_reg=8 alu_src=16 reg_dst=32 alu_op*64
  function automatic logic [7:0] m_decode(input logic [5:0] op);
    case (op)
      6'h00:   return 8'(1 + 32 + 2 * 64);
      6'h23:   return 8'(1 + 2 + 8 + 16);
      6'h2B:   return 8'(4 + 16);
      6'h08:   return 8'(1 + 16);
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic m_taken();
    logic [5:0] op;
    op = i_instruction[31:26];
    if (op == 6'h04) return m_read(i_rs) == m_read(i_rt);
    if (op == 6'h05) return m_read(i_rs) != m_read(i_rt);
    return op == 6'h02;
  endfunction

  function automatic logic [31:0] m_target();
    logic [31:0] ins;
    ins = i_instruction;
    if (ins[31:26] == 6'h02) return {i_pc_next[31:26], ins[25:0]};
    return i_pc_next + {{16{ins[15]}}, ins[15:0]};
  endfunction

  function automatic logic m_stall();
    return i_valid && !m_flush && m_load_dst != 5'd0 &&
           (m_load_dst == i_rs || m_load_dst == i_rt);
  endfunction

  function automatic logic m_src();
    return i_valid && !m_flush && !m_stall() && m_taken();
  endfunction

  always @(posedge i_clock) begin
    if (!i_reset) begin
      m_regs     = '{default: 32'd0};
      m_flush    = 1'b0;
      m_bubble   = 1'b0;
      m_load_dst = 5'd0;
      m_pc_next  = 32'd0;
      m_rs_val   = 32'd0;
      m_rt_val   = 32'd0;
      m_imm      = 32'd0;
      m_rs       = 5'd0;
      m_rt       = 5'd0;
      m_rd       = 5'd0;
      m_ctrl     = 8'd0;
    end else begin
      if (i_valid) begin
        m_squash   = m_flush || m_stall();
        m_src_now  = m_src();
        m_pc_next  = i_pc_next;
        m_rs_val   = m_read(i_rs);
        m_rt_val   = m_read(i_rt);
        m_imm      = {{16{i_instruction[15]}}, i_instruction[15:0]};
        m_rs       = i_rs;
        m_rt       = i_rt;
        m_rd       = i_instruction[15:11];
        m_ctrl     = m_squash ? 8'd0 : m_decode(i_instruction[31:26]);
        m_bubble   = m_squash;
        m_load_dst = (!m_squash && i_instruction[31:26] == 6'h23) ? i_rt : 5'd0;
        m_flush    = m_src_now;
      end
      if (i_wb_write && i_wb_addr != 5'd0) m_regs[i_wb_addr] = i_wb_data;
    end
  end

  always @(negedge i_clock) begin
    if (started) begin
      chk("stall", 32'(o_stall), 32'(m_stall()));
      chk("pc_src", 32'(o_pc_src), 32'(m_src()));
      chk("pc_branch", o_pc_branch, m_src() ? m_target() : 32'd0);
      chk("ctrl", 32'(o_ctrl), 32'(m_ctrl));
      if (!m_bubble) begin
        chk("pc_next", o_pc_next, m_pc_next);
        chk("data_rs", o_data_rs, m_rs_val);
        chk("data_rt", o_data_rt, m_rt_val);
        chk("immediate", o_immediate, m_imm);
        chk("rs", 32'(o_rs), 32'(m_rs));
        chk("rt", 32'(o_rt), 32'(m_rt));
        chk("rd", 32'(o_rd), 32'(m_rd));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic        s_stall, s_src;
  logic [31:0] s_br;

  function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] i_fmt(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_fmt(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  // Drive one decode cycle; comb outputs are sampled mid-cycle, and the task
  // returns 2 time units after the capturing edge.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic wbw, input logic [4:0] wba, input logic [31:0] wbd);
    i_valid       = v;
    i_pc_next     = pc;
    i_instruction = ins;
    i_rs          = ins[25:21];
    i_rt          = ins[20:16];
    i_wb_write    = wbw;
    i_wb_addr     = wba;
    i_wb_data     = wbd;
    @(negedge i_clock);
    #1;
    s_stall = o_stall;
    s_src   = o_pc_src;
    s_br    = o_pc_branch;
    @(posedge i_clock);
    #2;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] ins);
    drive(1'b1, pc, ins, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    drive(1'b1, 32'd0, NOP, 1'b1, a, d);
  endtask

  initial begin
    i_reset       = 1'b0;
    i_valid       = 1'b1;
    i_pc_next     = 32'd0;
    i_instruction = NOP;
    i_rs          = 5'd0;
    i_rt          = 5'd0;
    i_wb_write    = 1'b0;
    i_wb_addr     = 5'd0;
    i_wb_data     = 32'd0;
    @(posedge i_clock);
    started = 1'b1;
    repeat (4) @(posedge i_clock);
    #2;
    i_reset = 1'b1;
    chk("rst_ctrl", 32'(o_ctrl), 32'h0);
    chk("rst_pc_next", o_pc_next, 32'h0);
    chk("rst_data_rt", o_data_rt, 32'h0);
    chk("rst_stall", 32'(o_stall), 32'h0);

    issue(32'd1, r_add(5'd6, 5'd5, 5'd5));
    chk("r5_zero", o_data_rs, 32'h0);

    wb(5'd3, 32'h0000_00AA);
    issue(32'd2, r_add(5'd1, 5'd3, 5'd3));
    chk("add_rs", o_data_rs, 32'hAA);
    chk("add_rt", o_data_rt, 32'hAA);
    chk("add_ctrl", 32'(o_ctrl), 32'hA1);
    chk("add_rd", 32'(o_rd), 32'd1);

    wb(5'd0, 32'hFFFF_FFFF);
    issue(32'd3, r_add(5'd1, 5'd0, 5'd0));
    chk("r0_zero", o_data_rs, 32'h0);

    // load-use
    issue(32'd4, i_fmt(6'h23, 5'd0, 5'd2, 16'd4));
    chk("lw_ctrl", 32'(o_ctrl), 32'h1B);
    issue(32'd5, r_add(5'd4, 5'd2, 5'd2));
    chk("lu_stall", 32'(s_stall), 32'd1);
    chk("lu_bubble", 32'(o_ctrl), 32'h0);
    issue(32'd5, r_add(5'd4, 5'd2, 5'd2));
    chk("lu_stall_once", 32'(s_stall), 32'd0);
    chk("lu_reissue", 32'(o_ctrl), 32'hA1);

    // beq taken, squash, bne not taken
    wb(5'd1, 32'd7);
    wb(5'd2, 32'd7);
    issue(32'h10, i_fmt(6'h04, 5'd1, 5'd2, 16'hFFFC));
    chk("beq_src", 32'(s_src), 32'd1);
    chk("beq_target", s_br, 32'h0C);
    issue(32'h11, r_add(5'd5, 5'd1, 5'd1));
    chk("beq_squash", 32'(o_ctrl), 32'h0);
    chk("squash_src", 32'(s_src), 32'd0);
    issue(32'h0C, i_fmt(6'h05, 5'd1, 5'd2, 16'hFFFC));
    chk("bne_src", 32'(s_src), 32'd0);
    chk("bne_target", s_br, 32'd0);

    // jump
    issue(32'h20, j_fmt(26'h0000123));
    chk("j_src", 32'(s_src), 32'd1);
    chk("j_target", s_br, 32'h123);
    issue(32'h21, r_add(5'd5, 5'd1, 5'd1));
    chk("j_squash", 32'(o_ctrl), 32'h0);

    // stall beats branch
    issue(32'h40, i_fmt(6'h23, 5'd0, 5'd1, 16'd0));
    issue(32'h41, i_fmt(6'h04, 5'd1, 5'd1, 16'd2));
    chk("sb_stall", 32'(s_stall), 32'd1);
    chk("sb_no_src", 32'(s_src), 32'd0);
    issue(32'h41, i_fmt(6'h04, 5'd1, 5'd1, 16'd2));
    chk("sb_stall_clear", 32'(s_stall), 32'd0);
    chk("sb_src", 32'(s_src), 32'd1);
    chk("sb_target", s_br, 32'h43);
    issue(32'h42, NOP);

    // same-cycle writeback
    drive(1'b1, 32'h50, r_add(5'd8, 5'd7, 5'd7), 1'b1, 5'd7, 32'h55);
`ifdef DECODE_WB_BYPASS_EN
    chk("bypass_rs", o_data_rs, 32'h55);
`else
    chk("bypass_rs", o_data_rs, 32'h0);
`endif
    issue(32'h51, r_add(5'd8, 5'd7, 5'd0));
    chk("wb_visible", o_data_rs, 32'h55);

    // sw / addi decode and sign extension
    issue(32'h60, i_fmt(6'h2B, 5'd1, 5'd2, 16'h8000));
    chk("sw_ctrl", 32'(o_ctrl), 32'h14);
    chk("sw_imm", o_immediate, 32'hFFFF_8000);
    issue(32'h61, i_fmt(6'h08, 5'd1, 5'd9, 16'd5));
    chk("addi_ctrl", 32'(o_ctrl), 32'h11);

    // i_valid=0 freezes the stage but still accepts writeback
    drive(1'b0, 32'h70, j_fmt(26'd5), 1'b1, 5'd9, 32'h99);
    chk("inv_src", 32'(s_src), 32'd0);
    chk("inv_hold_ctrl", 32'(o_ctrl), 32'h11);
    chk("inv_hold_pc", o_pc_next, 32'h61);
    issue(32'h71, r_add(5'd10, 5'd9, 5'd9));
    chk("inv_wb", o_data_rs, 32'h99);

    issue(32'h80, i_fmt(6'h23, 5'd0, 5'd3, 16'd0));
    drive(1'b0, 32'h81, r_add(5'd4, 5'd3, 5'd3), 1'b0, 5'd0, 32'd0);
    chk("inv_no_stall", 32'(s_stall), 32'd0);
    issue(32'h81, r_add(5'd4, 5'd3, 5'd3));
    chk("valid_stall", 32'(s_stall), 32'd1);
    issue(32'h81, r_add(5'd4, 5'd3, 5'd3));
    chk("valid_reissue", 32'(o_ctrl), 32'hA1);

    issue(32'h82, NOP);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
